// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_queue
//  Purpose  : IF-stage fetch front end. Issues sequential fetches under a
//             credit limit and buffers {inst, pc} in an in-order queue.
//             Redirects flush the queue and drop stale in-flight responses.
//  Revision : 1.0
// ============================================================================
module fetch_queue #(
    parameter int               XLEN     = 32,
    parameter int               DEPTH    = 4,
    parameter logic [XLEN-1:0]  RESET_PC = '0
) (
    input  logic                         clk,
    input  logic                         rst_n,
    output logic                         o_im_req_valid,
    output logic [XLEN-1:0]              o_im_req_addr,
    input  logic                         i_im_req_ready,
    input  logic                         i_im_rsp_valid,
    input  logic [31:0]                  i_im_rsp_inst,
    input  logic                         i_redirect,
    input  logic [XLEN-1:0]              i_redirect_pc,
    input  logic                         i_deq_ready,
    output logic                         o_deq_valid,
    output logic [31:0]                  o_deq_inst,
    output logic [XLEN-1:0]              o_deq_pc,
    output logic [$clog2(DEPTH+1)-1:0]   o_count
);

    localparam int              CW      = $clog2(DEPTH + 1);
    localparam int              PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [31:0]     c_NOP   = 32'h0000_0013;
    localparam logic [CW:0]     c_LIMIT = (CW + 1)'(DEPTH);
    localparam logic [XLEN-1:0] c_STEP  = XLEN'(4);

    logic [XLEN-1:0] r_fetch_pc;
    logic [XLEN-1:0] r_resp_pc;
    logic [CW-1:0]   r_outstanding;
    logic [CW-1:0]   r_drop;
    logic [CW-1:0]   r_count;
    logic [PW-1:0]   r_rd;
    logic [PW-1:0]   r_wr;
    logic [31:0]     r_inst_mem [DEPTH];
    logic [XLEN-1:0] r_pc_mem   [DEPTH];

    logic [CW:0]     w_used;
    logic            w_has_credit;
    logic            w_req_fire;
    logic            w_rsp_take;
    logic            w_enq;
    logic            w_deq;
    logic [CW-1:0]   w_req_inc;
    logic [CW-1:0]   w_rsp_dec;
    logic [CW-1:0]   w_enq_inc;
    logic [CW-1:0]   w_deq_dec;

    // Credits count both queued and in-flight entries, so the queue can never overflow.
    assign w_used       = (CW + 1)'(r_outstanding) + (CW + 1)'(r_count);
    assign w_has_credit = (w_used < c_LIMIT);

    assign o_im_req_valid = rst_n && !i_redirect && w_has_credit;
    assign o_im_req_addr  = r_fetch_pc;

    assign w_req_fire = o_im_req_valid && i_im_req_ready;
    // A response with nothing outstanding belongs to a request issued before reset.
    assign w_rsp_take = i_im_rsp_valid && (r_outstanding != '0);
    assign w_enq      = w_rsp_take && (r_drop == '0) && !i_redirect;

    assign o_deq_valid = (r_count != '0) && !i_redirect;
    assign w_deq       = o_deq_valid && i_deq_ready;
    assign o_deq_inst  = o_deq_valid ? r_inst_mem[r_rd] : c_NOP;
    assign o_deq_pc    = o_deq_valid ? r_pc_mem[r_rd] : '0;
    assign o_count     = r_count;

    assign w_req_inc = CW'(w_req_fire);
    assign w_rsp_dec = CW'(w_rsp_take);
    assign w_enq_inc = CW'(w_enq);
    assign w_deq_dec = CW'(w_deq);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fetch_pc    <= RESET_PC;
            r_resp_pc     <= RESET_PC;
            r_outstanding <= '0;
            r_drop        <= '0;
            r_count       <= '0;
            r_rd          <= '0;
            r_wr          <= '0;
        end else if (i_redirect) begin
            // Everything still in flight (minus this cycle's arrival) is stale.
            r_fetch_pc    <= i_redirect_pc;
            r_resp_pc     <= i_redirect_pc;
            r_outstanding <= r_outstanding - w_rsp_dec;
            r_drop        <= r_outstanding - w_rsp_dec;
            r_count       <= '0;
            r_rd          <= '0;
            r_wr          <= '0;
        end else begin
            if (w_req_fire) begin
                r_fetch_pc <= r_fetch_pc + c_STEP;
            end
            r_outstanding <= r_outstanding + w_req_inc - w_rsp_dec;
            if (w_rsp_take) begin
                if (r_drop != '0) begin
                    r_drop <= r_drop - CW'(1);
                end else begin
                    r_wr      <= r_wr + PW'(1);
                    r_resp_pc <= r_resp_pc + c_STEP;
                end
            end
            if (w_deq) begin
                r_rd <= r_rd + PW'(1);
            end
            r_count <= r_count + w_enq_inc - w_deq_dec;
        end
    end

    // Payload storage needs no reset; r_count qualifies every read.
    always_ff @(posedge clk) begin
        if (w_enq) begin
            r_inst_mem[r_wr] <= i_im_rsp_inst;
            r_pc_mem[r_wr]   <= r_resp_pc;
        end
    end

endmodule
`default_nettype wire
